// File: rtl/dtc_clk_en_seq.sv
`default_nettype none
// ============================================================================
// dtc_clk_en_seq : lock-qualified, staggered DTC clock-gate enable sequencer
// Revision 1.0   : initial release
// ============================================================================
module dtc_clk_en_seq #(
    parameter int N_CH      = 40,
    parameter int GAP_W     = 8,
    parameter int HOLD_W    = 16,
    parameter int LOCK_HOLD = 1000,
    parameter int CNT_W     = 8
) (
    input  logic              dcsclk_i,
    input  logic              rstn_i,
    input  logic [N_CH-1:0]   en_req_i,
    input  logic              lock_in_i,
    input  logic [GAP_W-1:0]  stagger_cfg_i,
    input  logic              clr_status_i,
    output logic [N_CH-1:0]   dtc_clk_en_o,
    output logic              lock_ok_o,
    output logic              ramp_busy_o,
    output logic              lock_lost_flag_o,
    output logic [CNT_W-1:0]  lock_lost_cnt_o
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LOCK_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [N_CH-1:0]   CH_ONE    = N_CH'(1);

    state_t             state_q, state_d;
    logic               sync1_q, lock_s_q;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [N_CH-1:0]    en_q, en_d;
    logic               lock_ok_q, lock_ok_d;
    logic               busy_q, busy_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               loss;
    logic [N_CH-1:0]    pending;
    logic [N_CH-1:0]    lowest;

    assign pending = en_req_i & ~en_q;
    // Isolates the lowest set bit of pending.
    assign lowest  = pending & ~(pending - CH_ONE);

    always_ff @(posedge dcsclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= lock_in_i;
            lock_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        en_d    = en_q;
        loss    = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                en_d = '0;
                if (lock_s_q) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                en_d = '0;
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    loss    = 1'b1;
                end else if (hold_q == '0) begin
                    state_d = ST_RUN;
                    gap_d   = '0;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    en_d    = '0;
                    loss    = 1'b1;
                end else begin
                    // Drops take effect immediately; rises are paced by gap_cnt.
                    en_d = en_q & en_req_i;
                    if (gap_q != '0) begin
                        gap_d = gap_q - GAP_ONE;
                    end else if (pending != '0) begin
                        if (stagger_cfg_i != '0) begin
                            en_d  = en_d | lowest;
                            gap_d = stagger_cfg_i;
                        end else begin
                            en_d = en_d | pending;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                en_d    = '0;
            end
        endcase
    end

    always_comb begin
        lock_ok_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        busy_d    = lock_ok_d && ((en_req_i & ~en_d) != '0);
        flag_d    = flag_q;
        cnt_d     = cnt_q;
        if (loss) begin
            flag_d = 1'b1;
            if (clr_status_i) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (clr_status_i) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge dcsclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_WAIT_LOCK;
            hold_q    <= '0;
            gap_q     <= '0;
            en_q      <= '0;
            lock_ok_q <= 1'b0;
            busy_q    <= 1'b0;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            en_q      <= en_d;
            lock_ok_q <= lock_ok_d;
            busy_q    <= busy_d;
            flag_q    <= flag_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dtc_clk_en_o     = en_q;
    assign lock_ok_o        = lock_ok_q;
    assign ramp_busy_o      = busy_q;
    assign lock_lost_flag_o = flag_q;
    assign lock_lost_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dtc_clk_en_seq.sv
`default_nettype none
// ============================================================================
// tb_dtc_clk_en_seq : directed bench for dtc_clk_en_seq (N_CH=4, LOCK_HOLD=16)
// Revision 1.0      : initial release
// ============================================================================
module tb_dtc_clk_en_seq;

    logic       clk;
    logic       rstn;
    logic [3:0] en_req;
    logic       lock_in;
    logic [7:0] stagger;
    logic       clr;
    logic [3:0] dtc;
    logic       lock_ok;
    logic       busy;
    logic       flag;
    logic [7:0] cnt;

    int tests;
    int fails;

    dtc_clk_en_seq #(
        .N_CH      (4),
        .GAP_W     (8),
        .HOLD_W    (16),
        .LOCK_HOLD (16),
        .CNT_W     (8)
    ) u_dut (
        .dcsclk_i         (clk),
        .rstn_i           (rstn),
        .en_req_i         (en_req),
        .lock_in_i        (lock_in),
        .stagger_cfg_i    (stagger),
        .clr_status_i     (clr),
        .dtc_clk_en_o     (dtc),
        .lock_ok_o        (lock_ok),
        .ramp_busy_o      (busy),
        .lock_lost_flag_o (flag),
        .lock_lost_cnt_o  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rstn    = 1'b0;
        en_req  = 4'b0000;
        lock_in = 1'b0;
        stagger = 8'd0;
        clr     = 1'b0;
        #3;
        chk("rst_dtc", 32'(dtc), 32'h0);
        chk("rst_lock_ok", 32'(lock_ok), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        ticks(2);
        rstn = 1'b1;
        ticks(2);

        // 1: staggered ramp of 1011 with gap 3
        en_req  = 4'b1011;
        stagger = 8'd3;
        lock_in = 1'b1;
        ticks(19);
        chk("t1_lock_ok_early", 32'(lock_ok), 32'h0);
        chk("t1_dtc_early", 32'(dtc), 32'h0);
        ticks(1);
        chk("t1_lock_ok", 32'(lock_ok), 32'h1);
        chk("t1_dtc_b0", 32'(dtc), 32'h1);
        chk("t1_busy_b0", 32'(busy), 32'h1);
        ticks(3);
        chk("t1_dtc_gap", 32'(dtc), 32'h1);
        ticks(1);
        chk("t1_dtc_b1", 32'(dtc), 32'h3);
        chk("t1_busy_b1", 32'(busy), 32'h1);
        ticks(3);
        chk("t1_dtc_gap2", 32'(dtc), 32'h3);
        ticks(1);
        chk("t1_dtc_b3", 32'(dtc), 32'hB);
        chk("t1_busy_done", 32'(busy), 32'h0);

        // 2: reach 1111, then drop to 0101 with no stagger delay
        en_req = 4'b1111;
        ticks(3);
        chk("t2_dtc_wait", 32'(dtc), 32'hB);
        chk("t2_busy_wait", 32'(busy), 32'h1);
        ticks(1);
        chk("t2_dtc_full", 32'(dtc), 32'hF);
        chk("t2_busy_full", 32'(busy), 32'h0);
        en_req = 4'b0101;
        ticks(1);
        chk("t2_dtc_drop", 32'(dtc), 32'h5);
        chk("t2_busy_drop", 32'(busy), 32'h0);

        // 3: burst mode
        stagger = 8'd0;
        en_req  = 4'b0000;
        ticks(4);
        chk("t3_dtc_off", 32'(dtc), 32'h0);
        en_req = 4'b1111;
        ticks(1);
        chk("t3_dtc_burst", 32'(dtc), 32'hF);
        chk("t3_busy_burst", 32'(busy), 32'h0);

        // 4: lock loss mid-ramp, then relock
        stagger = 8'd3;
        en_req  = 4'b0000;
        ticks(2);
        chk("t4_dtc_off", 32'(dtc), 32'h0);
        en_req = 4'b1111;
        ticks(1);
        chk("t4_dtc_b0", 32'(dtc), 32'h1);
        ticks(4);
        chk("t4_dtc_b1", 32'(dtc), 32'h3);
        lock_in = 1'b0;
        ticks(2);
        chk("t4_dtc_sync", 32'(dtc), 32'h3);
        chk("t4_flag_sync", 32'(flag), 32'h0);
        ticks(1);
        chk("t4_dtc_lost", 32'(dtc), 32'h0);
        chk("t4_lock_ok_lost", 32'(lock_ok), 32'h0);
        chk("t4_busy_lost", 32'(busy), 32'h0);
        chk("t4_flag", 32'(flag), 32'h1);
        chk("t4_cnt", 32'(cnt), 32'h1);
        lock_in = 1'b1;
        ticks(19);
        chk("t4_relock_early", 32'(lock_ok), 32'h0);
        chk("t4_relock_dtc0", 32'(dtc), 32'h0);
        ticks(1);
        chk("t4_relock_ok", 32'(lock_ok), 32'h1);
        chk("t4_relock_b0", 32'(dtc), 32'h1);

        // 5: status clear, saturation, clear colliding with a loss
        clr = 1'b1;
        ticks(1);
        clr = 1'b0;
        chk("t5_clr_flag", 32'(flag), 32'h0);
        chk("t5_clr_cnt", 32'(cnt), 32'h0);
        chk("t5_clr_dtc", 32'(dtc), 32'h1);
        chk("t5_clr_lock_ok", 32'(lock_ok), 32'h1);
        lock_in = 1'b0;
        ticks(3);
        chk("t5_first_loss", 32'(cnt), 32'h1);
        ticks(1);
        for (int i = 0; i < 253; i++) begin
            lock_in = 1'b1;
            ticks(4);
            lock_in = 1'b0;
            ticks(4);
        end
        chk("t5_cnt_254", 32'(cnt), 32'd254);
        chk("t5_no_run", 32'(lock_ok), 32'h0);
        lock_in = 1'b1;
        ticks(4);
        lock_in = 1'b0;
        ticks(4);
        chk("t5_cnt_255", 32'(cnt), 32'd255);
        for (int i = 0; i < 5; i++) begin
            lock_in = 1'b1;
            ticks(4);
            lock_in = 1'b0;
            ticks(4);
        end
        chk("t5_cnt_sat", 32'(cnt), 32'd255);
        chk("t5_flag_sat", 32'(flag), 32'h1);
        lock_in = 1'b1;
        ticks(4);
        lock_in = 1'b0;
        ticks(2);
        clr = 1'b1;
        ticks(1);
        clr = 1'b0;
        chk("t5_clr_loss_flag", 32'(flag), 32'h1);
        chk("t5_clr_loss_cnt", 32'(cnt), 32'h1);

        // 6: asynchronous reset mid-ramp
        lock_in = 1'b1;
        en_req  = 4'b1111;
        ticks(20);
        chk("t6_ramp_b0", 32'(dtc), 32'h1);
        ticks(4);
        chk("t6_ramp_b1", 32'(dtc), 32'h3);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_dtc", 32'(dtc), 32'h0);
        chk("t6_rst_lock_ok", 32'(lock_ok), 32'h0);
        chk("t6_rst_flag", 32'(flag), 32'h0);
        chk("t6_rst_cnt", 32'(cnt), 32'h0);
        ticks(2);
        rstn = 1'b1;
        ticks(19);
        chk("t6_wait_lock_ok", 32'(lock_ok), 32'h0);
        chk("t6_wait_dtc", 32'(dtc), 32'h0);
        ticks(1);
        chk("t6_rerun_ok", 32'(lock_ok), 32'h1);
        chk("t6_rerun_b0", 32'(dtc), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
